water_level_scan_ctrl: RTL and testbench
========================================

# water_level_scan_ctrl

Sequencer for the water-level dot-matrix display path in the irrigation controller. It scans the five display columns (C0..C4) in turn with a one-cycle blanking gap, synchronises and debounces the raw high/mid/low reservoir sensors, and presents a validated, frame-stable h/m/l triple to the level decoder. Sensor updates take effect only at frame boundaries, so a displayed frame never mixes two levels. Physically impossible sensor combinations are flagged and rejected.

## Interface
- SCAN_DIV, 1000: clock cycles each column stays active (>= 1).
- DEB_LEN, 4: consecutive identical synchronised samples needed to accept a new sensor vector (>= 1).
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = scan display; 0 = blank display and park the scanner.
- h_raw, m_raw, l_raw  in  1 each  asynchronous raw level sensors (1 = water at that probe).
- h, m, l  out  1 each  validated levels to the decoder, updated only at frame boundary.
- col  out  5  one-hot column select, bit i = Ci, active high; 0 = blanked.
- frame_done  out  1  one-cycle pulse at the end of each completed C0..C4 sweep.
- sensor_err  out  1  last boundary-sampled debounced vector was invalid.

## Operation
- Sync: each raw sensor passes through 2 flip-flops, giving a synchronised vector s = {h,m,l}.
- Debounce:
  - Counter cnt resets to 0 whenever s differs from its value on the previous cycle; otherwise it increments, saturating at DEB_LEN.
  - When cnt reaches DEB_LEN, register deb <= s.
  - deb resets to 000.
- Validity: valid deb values are 000, 001, 011, 111. Any other value is invalid.
- FSM states are IDLE, BLANK and COL, plus a column index idx 0..4 and a dwell counter.
  - IDLE: col = 0, idx = 0. If enable = 1, go to BLANK.
  - BLANK: lasts exactly 1 cycle with col = 0, then go to COL.
  - COL: col = one-hot(idx) for SCAN_DIV cycles, then go to BLANK with idx <= idx+1. idx wraps 4 -> 0.
  - enable = 0 in any state: go to IDLE on the next edge. idx and dwell are cleared, with no frame_done and no h/m/l update.
- Frame boundary is the BLANK cycle entered from COL with idx = 4. In that cycle:
  - frame_done = 1.
  - If deb is valid: {h,m,l} <= deb and sensor_err <= 0.
  - If deb is invalid: h/m/l hold their old value and sensor_err <= 1.
- The BLANK entered from IDLE is not a frame boundary.

## Timing
- Reset values: col = 0, h = m = l = 0, frame_done = 0, sensor_err = 0. FSM = IDLE, idx = 0, cnt = 0.
- Reset is honoured mid-scan immediately and asynchronously. After release, the first edge with enable = 1 moves to BLANK; the next edge activates C0.
- Frame length: 5 x (SCAN_DIV + 1) cycles, measured from one frame_done to the next while enable stays high.
- Sensor latency: a raw step stable throughout reaches deb 2 + DEB_LEN cycles after it is sampled. It then waits up to one frame for the boundary.
- col is fully registered, and never has two bits set.
- Simultaneous events:
  - If deb updates in the same cycle as the boundary, the boundary samples the old deb.
  - If enable falls in the boundary cycle, frame_done still pulses in that cycle; the next state is IDLE.
- Sensor glitches shorter than DEB_LEN cycles (after sync) never reach deb.

## Test plan
Bench parameters: SCAN_DIV = 4, DEB_LEN = 3, so a frame is 25 cycles.
- Reset, then enable = 1: cycle 1 col = 0 (BLANK), cycles 2-5 col = 00001, cycle 6 col = 0, cycles 7-10 col = 00010, ... The first frame_done falls at cycle 26, then every 25 cycles. col is never multi-hot.
- Hold raw = 011 from reset with enable = 1: h/m/l = 011 at the first frame_done and sensor_err = 0. Step raw to 111 mid-frame: outputs stay 011 until the next frame_done, then become 111.
- Glitch raw 011 -> 111 for 2 cycles, then back: deb never changes and h/m/l stay 011. The same pulse held for 3 cycles or more is accepted at the next boundary.
- Raw = 101 stable with prior h/m/l = 001: at the boundary sensor_err = 1 and h/m/l stay 001. Raw then goes to 000: at the next boundary sensor_err = 0 and h/m/l = 000.
- Drop enable during C2: col = 0 on the next cycle and there is no frame_done. Re-enable: BLANK, then C0. The next frame_done comes 26 cycles after re-enable.
- Assert rst_n = 0 during C3 with h/m/l = 111: all outputs go to 0 immediately. After release the scan restarts from IDLE.

Source files
------------

// File: rtl/water_level_scan_ctrl.sv
// Column scanner for the water-level dot-matrix display with sensor sync/debounce.
// Level outputs change only at the frame boundary so a frame never shows two levels.
module water_level_scan_ctrl #(
    parameter int SCAN_DIV = 1000,
    parameter int DEB_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       h_raw,
    input  logic       m_raw,
    input  logic       l_raw,
    output logic       h,
    output logic       m,
    output logic       l,
    output logic [4:0] col,
    output logic       frame_done,
    output logic       sensor_err
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEB_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        COL   = 2'd2
    } state_t;

    // Only water filling from the bottom probe upward is physically possible.
    function automatic logic level_valid(input logic [2:0] v);
        case (v)
            3'b000, 3'b001, 3'b011, 3'b111: level_valid = 1'b1;
            default:                        level_valid = 1'b0;
        endcase
    endfunction

    logic [2:0]    sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    deb_q, deb_d;
    state_t        state_q;
    logic [2:0]    idx_q;
    logic [DW-1:0] dwell_q;
    logic [4:0]    col_q;
    logic          frame_done_q;
    logic [2:0]    hml_q;
    logic          err_q;

    // Debounce next state: cnt_q counts extra cycles the synchronised vector has held.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync1_q != sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
        if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
        end else begin
            deb_d = deb_q;
        end
    end

    // Two-flop synchroniser and debounce registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            cnt_q   <= '0;
            deb_q   <= 3'b000;
        end else begin
            sync1_q <= {h_raw, m_raw, l_raw};
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
        end
    end

    // Scan FSM with registered column, frame pulse and boundary-latched levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            dwell_q      <= '0;
            col_q        <= 5'b00000;
            frame_done_q <= 1'b0;
            hml_q        <= 3'b000;
            err_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (!enable) begin
                state_q <= IDLE;
                idx_q   <= 3'd0;
                dwell_q <= '0;
                col_q   <= 5'b00000;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= BLANK;
                        idx_q   <= 3'd0;
                        dwell_q <= '0;
                        col_q   <= 5'b00000;
                    end
                    BLANK: begin
                        state_q <= COL;
                        dwell_q <= '0;
                        col_q   <= 5'b00001 << idx_q;
                    end
                    COL: begin
                        if (dwell_q == DWELL_LAST) begin
                            state_q <= BLANK;
                            dwell_q <= '0;
                            col_q   <= 5'b00000;
                            if (idx_q == 3'd4) begin
                                idx_q        <= 3'd0;
                                frame_done_q <= 1'b1;
                                if (level_valid(deb_q)) begin
                                    hml_q <= deb_q;
                                    err_q <= 1'b0;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else begin
                            dwell_q <= dwell_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        idx_q   <= 3'd0;
                        dwell_q <= '0;
                        col_q   <= 5'b00000;
                    end
                endcase
            end
        end
    end

    assign col        = col_q;
    assign frame_done = frame_done_q;
    assign {h, m, l}  = hml_q;
    assign sensor_err = err_q;

endmodule

// File: tb/tb_water_level_scan_ctrl.sv
// Randomised and directed bench for water_level_scan_ctrl against a frame-position
// arithmetic model and a raw-sample history debounce model.
module tb_water_level_scan_ctrl;

    localparam int SD    = 4;
    localparam int DL    = 3;
    localparam int FRAME = 5 * (SD + 1);
    localparam int HMAX  = 8192;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [2:0] raw;
    logic       h, m, l;
    logic [4:0] col;
    logic       frame_done;
    logic       sensor_err;

    water_level_scan_ctrl #(.SCAN_DIV(SD), .DEB_LEN(DL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .h_raw      (raw[2]),
        .m_raw      (raw[1]),
        .l_raw      (raw[0]),
        .h          (h),
        .m          (m),
        .l          (l),
        .col        (col),
        .frame_done (frame_done),
        .sensor_err (sensor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] hist [HMAX];
    int         ecount = 0;
    int         base   = 0;
    int         t_m    = -1;
    logic [2:0] deb_m  = 3'b000;
    logic [2:0] hml_m  = 3'b000;
    logic       err_m  = 1'b0;
    logic [4:0] col_m  = 5'b00000;
    logic       fd_m   = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [2:0] raw_at(input int j);
        if (j < base) return 3'b000;
        return hist[j];
    endfunction

    function automatic bit is_level(input logic [2:0] v);
        return (v == 3'd0) || (v == 3'd1) || (v == 3'd3) || (v == 3'd7);
    endfunction

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic tick();
        int k, p, c, o;
        logic [2:0] s_pre, deb_new;
        bit eq;
        @(posedge clk);
        k = ecount;
        hist[k] = raw;
        ecount++;
        s_pre = raw_at(k - 2);
        eq = 1'b1;
        for (int j = k - 2; j >= k - 1 - DL; j--)
            if (raw_at(j) !== s_pre) eq = 1'b0;
        deb_new = eq ? s_pre : deb_m;
        fd_m = 1'b0;
        if (!enable) begin
            t_m = -1;
            col_m = 5'b00000;
        end else if (t_m < 0) begin
            t_m = 0;
            col_m = 5'b00000;
        end else begin
            t_m++;
            p = (t_m - 1) % FRAME;
            c = p / (SD + 1);
            o = p % (SD + 1);
            if (o < SD) begin
                col_m = 5'(1 << c);
            end else begin
                col_m = 5'b00000;
                if (c == 4) begin
                    fd_m = 1'b1;
                    if (is_level(deb_m)) begin
                        hml_m = deb_m;
                        err_m = 1'b0;
                    end else begin
                        err_m = 1'b1;
                    end
                end
            end
        end
        deb_m = deb_new;
        #1;
        check("col", col, col_m);
        check("frame_done", frame_done, fd_m);
        check("hml", {h, m, l}, hml_m);
        check("sensor_err", sensor_err, err_m);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_boundary();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fd_m && n < 2 * FRAME + 10);
        if (!fd_m) check("boundary_timeout", 8'(fd_m), 8'd1);
    endtask

    // Counts cycles from the first enabled edge to the first frame_done.
    task automatic frame_latency(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        check(tag, 8'(n), 8'(FRAME + 1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_col", col, 8'd0);
        check("rst_fd", frame_done, 8'd0);
        check("rst_hml", {h, m, l}, 8'd0);
        check("rst_err", sensor_err, 8'd0);
        t_m = -1; deb_m = 3'b000; hml_m = 3'b000; err_m = 1'b0;
        col_m = 5'b00000; fd_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = ecount;
        rst_n = 1'b1;
    endtask

    task automatic wait_col(input logic [4:0] target);
        int n;
        n = 0;
        while (col_m != target && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (col_m != target) check("wait_col_timeout", 8'(col_m), 8'(target));
    endtask

    initial begin
        int hold;
        rst_n = 1'b0; enable = 1'b0; raw = 3'b000;
        do_reset();
        run(3);

        raw = 3'b011; enable = 1'b1;
        frame_latency("first_fd_cycle");
        check("first_hml", {h, m, l}, 8'h3);
        check("first_err", sensor_err, 8'd0);
        run(12);
        raw = 3'b111;
        run(5);
        check("step_hold", {h, m, l}, 8'h3);
        wait_boundary();
        check("step_hml", {h, m, l}, 8'h7);

        raw = 3'b011;
        wait_boundary();
        run(7);
        raw = 3'b111;
        run(2);
        raw = 3'b011;
        wait_boundary();
        check("glitch_rej", {h, m, l}, 8'h3);
        run(4);
        raw = 3'b111;
        run(3);
        raw = 3'b011;
        wait_boundary();
        wait_boundary();

        raw = 3'b001;
        wait_boundary();
        wait_boundary();
        check("pre_inv_hml", {h, m, l}, 8'h1);
        raw = 3'b101;
        wait_boundary();
        check("inv_err", sensor_err, 8'd1);
        check("inv_hold", {h, m, l}, 8'h1);
        raw = 3'b000;
        wait_boundary();
        check("rec_err", sensor_err, 8'd0);
        check("rec_hml", {h, m, l}, 8'h0);

        wait_col(5'b00100);
        tick();
        enable = 1'b0;
        tick();
        check("dis_col", col, 8'd0);
        run(4);
        enable = 1'b1;
        frame_latency("reen_fd_cycle");

        raw = 3'b111;
        wait_boundary();
        wait_boundary();
        wait_col(5'b01000);
        tick();
        check("pre_rst_hml", {h, m, l}, 8'h7);
        #2;
        do_reset();
        frame_latency("post_rst_fd");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                case ($urandom_range(0, 3))
                    0: raw = 3'b000;
                    1: raw = 3'b001;
                    2: raw = 3'b011;
                    default: raw = 3'b111;
                endcase
            end else begin
                raw = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 29) == 0) enable = 1'b0;
            else enable = 1'b1;
            hold = $urandom_range(1, 12);
            run(hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
